// File: rtl/spike_event_collector.sv
// Captures rising edges on per-neuron spike lines, queues one event per neuron per timestep,
// and serialises them round-robin as neuron addresses on a valid/ready stream.
module spike_event_collector #(
    parameter int NUM_NEURONS  = 10,
    parameter int ADDR_WIDTH   = 12,
    parameter int BASE_ADDRESS = 0,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_address,
    output logic [NUM_NEURONS-1:0] pending,
    output logic [CNT_WIDTH-1:0]   event_count,
    output logic                   dup_drop,
    output logic                   idle
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [0:0]             state;
    logic [NUM_NEURONS-1:0] spike_q;
    logic [NUM_NEURONS-1:0] sent;
    logic [NUM_NEURONS-1:0] rise;
    logic [NUM_NEURONS-1:0] new_bits;
    logic [NUM_NEURONS-1:0] hs_mask;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       grant_next;
    logic                   found;
    logic                   handshake;
    logic                   dup_hit;

    function automatic logic [ADDR_WIDTH-1:0] neuron_address(input logic [IDX_W-1:0] idx);
        return ADDR_WIDTH'(BASE_ADDRESS) + ADDR_WIDTH'(idx);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // A neuron already queued or already emitted this timestep cannot queue again.
    assign rise      = spike_in & ~spike_q;
    assign new_bits  = rise & ~pending & ~sent;
    assign dup_hit   = |(rise & (pending | sent));
    assign handshake = (state == HOLD) && out_ready;
    assign hs_mask   = handshake ? (NUM_NEURONS'(1) << grant) : '0;
    assign out_valid = (state == HOLD);
    assign idle      = (state == ARB) && (pending == '0);

    // Search upward from rr_ptr, wrapping past the last neuron.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        found      = 1'b0;
        grant_next = '0;
        idx        = 0;
        cand       = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_NEURONS) idx = idx - NUM_NEURONS;
            cand = IDX_W'(idx);
            if (!found && pending[cand]) begin
                found      = 1'b1;
                grant_next = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ARB;
            spike_q     <= '0;
            pending     <= '0;
            sent        <= '0;
            event_count <= '0;
            dup_drop    <= 1'b0;
            rr_ptr      <= '0;
            grant       <= '0;
            out_address <= '0;
        end else begin
            spike_q <= spike_in;
            if (clear) begin
                state       <= ARB;
                pending     <= '0;
                sent        <= '0;
                event_count <= '0;
                dup_drop    <= 1'b0;
                rr_ptr      <= '0;
            end else begin
                pending <= (pending | new_bits) & ~hs_mask;
                sent    <= sent | hs_mask;
                if (dup_hit) dup_drop <= 1'b1;
                case (state)
                    ARB: begin
                        if (found) begin
                            grant       <= grant_next;
                            out_address <= neuron_address(grant_next);
                            state       <= HOLD;
                        end
                    end
                    default: begin
                        if (out_ready) begin
                            event_count <= event_count + CNT_WIDTH'(1);
                            rr_ptr      <= next_ptr(grant);
                            state       <= ARB;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_event_collector.sv
// Directed bench for spike_event_collector: edge capture, round-robin order,
// backpressure, duplicate suppression, clear and asynchronous reset.
module tb_spike_event_collector;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        clear;
    logic [9:0]  spike_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_address;
    logic [9:0]  pending;
    logic [3:0]  event_count;
    logic        dup_drop;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    spike_event_collector #(
        .NUM_NEURONS(10), .ADDR_WIDTH(12), .BASE_ADDRESS(0), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .clear(clear), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
        .pending(pending), .event_count(event_count), .dup_drop(dup_drop), .idle(idle)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; clear = 1'b0; spike_in = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(out_address), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_count", 32'(event_count), 0);
        check("rst_dup", 32'(dup_drop), 0);
        check("rst_idle", 32'(idle), 1);
        RESET_N = 1'b1;
        tick();

        // single spike on neuron 3
        spike_in = 10'(1 << 3);
        tick();
        check("single_pending", 32'(pending), 32'h8);
        check("single_valid_early", 32'(out_valid), 0);
        check("single_idle_busy", 32'(idle), 0);
        spike_in = '0;
        tick();
        check("single_valid", 32'(out_valid), 1);
        check("single_addr", 32'(out_address), 3);
        tick();
        check("single_valid_drop", 32'(out_valid), 0);
        check("single_pending_clr", 32'(pending), 0);
        check("single_count", 32'(event_count), 1);
        check("single_idle", 32'(idle), 1);

        // simultaneous 2,5,7 then wrap to 0
        do_clear();
        check("clr_count", 32'(event_count), 0);
        spike_in = 10'h0A4;
        tick();
        check("sim_pending", 32'(pending), 32'h0A4);
        spike_in = '0;
        tick();
        check("sim_addr0", 32'(out_address), 2);
        tick();
        check("sim_gap", 32'(out_valid), 0);
        tick();
        check("sim_addr1", 32'(out_address), 5);
        tick();
        tick();
        check("sim_addr2", 32'(out_address), 7);
        spike_in = 10'h001;
        tick();
        check("wrap_pending", 32'(pending), 32'h001);
        check("wrap_count", 32'(event_count), 3);
        spike_in = '0;
        tick();
        check("wrap_valid", 32'(out_valid), 1);
        check("wrap_addr", 32'(out_address), 0);
        tick();
        check("wrap_count2", 32'(event_count), 4);

        // round-robin: 1 and 8 pending with rr_ptr=6
        do_clear();
        spike_in = 10'(1 << 5);
        tick();
        spike_in = '0; out_ready = 1'b0;
        tick();
        check("rr_hold5", 32'(out_address), 5);
        spike_in = 10'h102;
        tick();
        check("rr_pending", 32'(pending), 32'h122);
        spike_in = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rr_first", 32'(out_address), 8);
        tick();
        tick();
        check("rr_second", 32'(out_address), 1);
        tick();
        check("rr_count", 32'(event_count), 3);

        // backpressure on neuron 4, spike on 6 during hold
        do_clear();
        spike_in = 10'(1 << 4);
        tick();
        spike_in = '0; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            spike_in = (i == 1) ? 10'(1 << 6) : 10'h000;
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_addr", 32'(out_address), 4);
        end
        check("bp_pending", 32'(pending), 32'h050);
        out_ready = 1'b1;
        tick();
        check("bp_hs", 32'(out_valid), 0);
        tick();
        check("bp_next", 32'(out_address), 6);
        tick();
        check("bp_count", 32'(event_count), 2);

        // duplicate on neuron 9 in one timestep
        do_clear();
        spike_in = 10'(1 << 9);
        tick();
        spike_in = '0;
        tick();
        check("dup_addr", 32'(out_address), 9);
        tick();
        spike_in = 10'(1 << 9);
        tick();
        check("dup_flag", 32'(dup_drop), 1);
        check("dup_pending", 32'(pending), 0);
        spike_in = '0;
        tick(); tick();
        check("dup_no_event", 32'(out_valid), 0);
        check("dup_count", 32'(event_count), 1);
        do_clear();
        check("dup_cleared", 32'(dup_drop), 0);
        spike_in = 10'(1 << 9);
        tick();
        spike_in = '0;
        tick();
        check("dup_again_valid", 32'(out_valid), 1);
        check("dup_again_addr", 32'(out_address), 9);
        tick();

        // held neuron re-spiking counts as duplicate
        do_clear();
        spike_in = 10'(1 << 2);
        tick();
        spike_in = '0; out_ready = 1'b0;
        tick();
        spike_in = 10'(1 << 2);
        tick();
        check("held_dup", 32'(dup_drop), 1);
        spike_in = '0; out_ready = 1'b1;
        tick();

        // clear during HOLD of 5 with 8 also pending
        do_clear();
        spike_in = 10'h120;
        tick();
        spike_in = '0; out_ready = 1'b0;
        tick();
        check("clr_hold_addr", 32'(out_address), 5);
        check("clr_hold_pend", 32'(pending), 32'h120);
        do_clear();
        check("clr_valid", 32'(out_valid), 0);
        check("clr_pending", 32'(pending), 0);
        check("clr_count2", 32'(event_count), 0);
        check("clr_idle", 32'(idle), 1);
        out_ready = 1'b1;
        tick(); tick();
        check("clr_no8", 32'(out_valid), 0);

        // rising edge coinciding with clear is discarded, level held across clear gives no edge
        spike_in = 10'(1 << 1); clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_edge_drop", 32'(pending), 0);
        tick();
        check("clr_level_held", 32'(pending), 0);
        spike_in = '0;
        tick();

        // asynchronous reset during HOLD
        spike_in = 10'(1 << 3);
        tick();
        spike_in = '0; out_ready = 1'b0;
        tick();
        check("arst_hold", 32'(out_valid), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_idle", 32'(idle), 1);
        #2;
        RESET_N = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        check("arst_quiet", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
